// File: rtl/data_parse.sv
// data_parse: receive-side decoder splitting INFO/DATA packets into device status and per-device sample streams
module data_parse #(
    parameter logic [15:0] TIMEOUT = 16'd1000,
    parameter logic [3:0]  IDX_MAX = 4'h5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] dev_stat,
    output logic [63:0] dev_temp,
    output logic        info_done,
    output logic [7:0]  hdr_com,
    output logic [3:0]  hdr_idx,
    output logic [7:0]  dout,
    output logic [2:0]  dout_dev,
    output logic        dout_valid,
    output logic        dout_last,
    output logic [31:0] trgg,
    output logic        data_done,
    output logic        err,
    output logic [2:0]  err_code
);
    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_INFO, S_DHDR, S_DSEL, S_DPAY, S_DTRG, S_DONE
    } state_t;
    localparam logic [2:0] E_SYNC  = 3'd1;
    localparam logic [2:0] E_INFO  = 3'd2;
    localparam logic [2:0] E_NOLEN = 3'd3;
    localparam logic [2:0] E_TOUT  = 3'd4;
    localparam logic [2:0] E_IDX   = 3'd5;
    state_t      r_state;
    logic        r_live;
    logic        r_is_data;
    logic [11:0] r_cnt;
    logic [15:0] r_idle;
    logic [3:0]  r_dev;
    logic [9:0]  r_dlen;
    logic [15:0] r_sh_stat;
    logic [63:0] r_sh_temp;
    logic [15:0] r_dev_stat;
    logic [63:0] r_dev_temp;
    logic        r_info_done;
    logic [7:0]  r_hdr_com;
    logic [3:0]  r_hdr_idx;
    logic [7:0]  r_dout;
    logic [2:0]  r_dout_dev;
    logic        r_dout_valid;
    logic        r_dout_last;
    logic [31:0] r_trgg;
    logic        r_data_done;
    logic        r_err;
    logic [2:0]  r_err_code;
    logic        w_acc;
    logic        w_tout;
    logic [1:0]  w_code;
    logic        w_sel;
    logic [9:0]  w_len;
    logic        w_last;
    // r_live keeps rx_ready low while reset is held and in the first cycle after it
    assign rx_ready = r_live && (r_state != S_DSEL) && (r_state != S_DONE);
    assign w_acc    = rx_valid && rx_ready;
    assign w_tout   = (r_state != S_IDLE) && !w_acc && (r_idle == TIMEOUT - 16'd1);
    assign w_code   = 2'(r_dev_stat >> (4'd14 - {r_dev[2:0], 1'b0}));
    assign w_sel    = r_hdr_com[3'd7 - r_dev[2:0]];
    assign w_len    = 10'd64 << w_code;
    assign w_last   = r_cnt == ({2'b00, r_dlen} - 12'd1);
    assign dev_stat   = r_dev_stat;
    assign dev_temp   = r_dev_temp;
    assign info_done  = r_info_done;
    assign hdr_com    = r_hdr_com;
    assign hdr_idx    = r_hdr_idx;
    assign dout       = r_dout;
    assign dout_dev   = r_dout_dev;
    assign dout_valid = r_dout_valid;
    assign dout_last  = r_dout_last;
    assign trgg       = r_trgg;
    assign data_done  = r_data_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    // Idle counter: cycles inside a packet without an accepted byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_idle <= '0;
        else
            r_idle <= (r_state == S_IDLE || w_acc) ? 16'd0 : r_idle + 16'd1;
    end
    // Packet FSM with all registered outputs; byte counter restarts on every state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_live       <= 1'b0;
            r_is_data    <= 1'b0;
            r_cnt        <= '0;
            r_dev        <= '0;
            r_dlen       <= '0;
            r_sh_stat    <= '0;
            r_sh_temp    <= '0;
            r_dev_stat   <= '0;
            r_dev_temp   <= '0;
            r_info_done  <= 1'b0;
            r_hdr_com    <= '0;
            r_hdr_idx    <= '0;
            r_dout       <= '0;
            r_dout_dev   <= '0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_trgg       <= '0;
            r_data_done  <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= '0;
        end else begin
            r_live       <= 1'b1;
            r_info_done  <= 1'b0;
            r_data_done  <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_err        <= 1'b0;
            if (w_acc)
                r_cnt <= r_cnt + 12'd1;
            if (w_tout) begin
                r_err      <= 1'b1;
                r_err_code <= E_TOUT;
                r_state    <= S_IDLE;
                r_cnt      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt <= '0;
                        if (w_acc && (rx_data == 8'h66 || rx_data == 8'h55)) begin
                            r_is_data <= rx_data == 8'h55;
                            r_state   <= S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        if (w_acc) begin
                            r_cnt <= '0;
                            if (rx_data == (r_is_data ? 8'hAA : 8'hBB)) begin
                                r_state <= r_is_data ? S_DHDR : S_INFO;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_code <= E_SYNC;
                                r_state    <= S_IDLE;
                            end
                        end
                    end
                    S_INFO: begin
                        if (w_acc) begin
                            if ((r_cnt == 12'd0 && rx_data != 8'h00) || (r_cnt == 12'd1 && rx_data != 8'h1E)) begin
                                r_err      <= 1'b1;
                                r_err_code <= E_INFO;
                                r_state    <= S_IDLE;
                                r_cnt      <= '0;
                            end else begin
                                if (r_cnt == 12'd2)
                                    r_sh_stat[15:8] <= rx_data;
                                if (r_cnt == 12'd3)
                                    r_sh_stat[7:0] <= rx_data;
                                r_sh_temp <= {r_sh_temp[55:0], rx_data};
                                if (r_cnt == 12'd11) begin
                                    r_dev_stat  <= r_sh_stat;
                                    r_dev_temp  <= {r_sh_temp[55:0], rx_data};
                                    r_info_done <= 1'b1;
                                    r_state     <= S_IDLE;
                                    r_cnt       <= '0;
                                end
                            end
                        end
                    end
                    S_DHDR: begin
                        if (w_acc) begin
                            if (r_cnt == 12'd0) begin
                                r_hdr_com <= rx_data;
                            end else begin
                                r_hdr_idx <= rx_data[3:0];
                                r_cnt     <= '0;
                                r_dev     <= '0;
                                if (rx_data[7:4] != 4'd0 || rx_data[3:0] > IDX_MAX) begin
                                    r_err      <= 1'b1;
                                    r_err_code <= E_IDX;
                                    r_state    <= S_IDLE;
                                end else begin
                                    r_state <= S_DSEL;
                                end
                            end
                        end
                    end
                    S_DSEL: begin
                        r_cnt <= '0;
                        if (r_dev[3]) begin
                            r_state <= S_DTRG;
                        end else if (!w_sel) begin
                            r_dev <= r_dev + 4'd1;
                        end else if (w_code == 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= E_NOLEN;
                            r_state    <= S_IDLE;
                        end else begin
                            r_dlen  <= w_len;
                            r_state <= S_DPAY;
                        end
                    end
                    S_DPAY: begin
                        if (w_acc) begin
                            r_dout       <= rx_data;
                            r_dout_dev   <= r_dev[2:0];
                            r_dout_valid <= 1'b1;
                            r_dout_last  <= w_last;
                            if (w_last) begin
                                r_dev   <= r_dev + 4'd1;
                                r_state <= S_DSEL;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    S_DTRG: begin
                        if (w_acc) begin
                            r_trgg <= {r_trgg[23:0], rx_data};
                            if (r_cnt == 12'd3) begin
                                r_data_done <= 1'b1;
                                r_state     <= S_DONE;
                                r_cnt       <= '0;
                            end
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
